input_conditioner: RTL and testbench

//  Two-channel input front end feeding the 2-input x/y sequence FSM (in_x, in_y).

---
 rtl/input_conditioner_pkg.sv | 20 ++
 rtl/input_conditioner_debounce_chan.sv | 107 ++++++++++
 rtl/input_conditioner.sv | 65 ++++++
 tb/tb_input_conditioner.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: channel state encodings and default sizing.
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        LO      = 2'b00,
        WAIT_HI = 2'b01,
        HI      = 2'b11,
        WAIT_LO = 2'b10
    } chan_state_e;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 8;
    localparam int DEF_CNT_W         = 4;

    // A channel is settled when no candidate level is pending.
    function automatic logic is_settled(input chan_state_e st);
        return (st == LO) || (st == HI);
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_chan.sv
// One input channel: synchroniser chain, debounce counter and level FSM.
// Optional one-cycle rise/fall pulses are built when COND_EDGE_EN is defined.
module debounce_chan
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset_b,
    input  logic raw_i,
    output logic level_o,
    output logic settled_o
`ifdef COND_EDGE_EN
    ,
    output logic rise_o,
    output logic fall_o
`endif
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("debounce_chan: SYNC_STAGES must be 2..3");
    end
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > (2**CNT_W) - 1) begin : g_bad_stable
        $error("debounce_chan: STABLE_CYCLES must be 2..2**CNT_W-1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    chan_state_e            state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   s;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // cnt_q holds the number of consecutive candidate samples seen so far;
    // it peaks at STABLE_CYCLES-1, so it can never wrap.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= LO;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                LO: if (s) begin
                    state_q <= WAIT_HI;
                    cnt_q   <= CNT_W'(1);
                end
                WAIT_HI: if (!s) begin
                    state_q <= LO;
                    cnt_q   <= '0;
                end else if (cnt_q == LAST) begin
                    state_q <= HI;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                HI: if (!s) begin
                    state_q <= WAIT_LO;
                    cnt_q   <= CNT_W'(1);
                end
                WAIT_LO: if (s) begin
                    state_q <= HI;
                    cnt_q   <= '0;
                end else if (cnt_q == LAST) begin
                    state_q <= LO;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                default: begin
                    state_q <= LO;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Bit 1 of the encoding is the accepted level (HI and WAIT_LO).
    assign level_o   = state_q[1];
    assign settled_o = is_settled(state_q);

`ifdef COND_EDGE_EN
    logic rise_q, fall_q;

    // Pulses land on the same edge the level register takes its new value.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= (state_q == WAIT_HI) && s  && (cnt_q == LAST);
            fall_q <= (state_q == WAIT_LO) && !s && (cnt_q == LAST);
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Two-channel synchronise-and-debounce front end for the x/y sequence FSM.
// Define COND_EDGE_EN to add registered x/y rise/fall pulse outputs.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset_b,
    input  logic raw_x,
    input  logic raw_y,
    output logic in_x,
    output logic in_y,
    output logic stable
`ifdef COND_EDGE_EN
    ,
    output logic x_rise,
    output logic x_fall,
    output logic y_rise,
    output logic y_fall
`endif
);

    logic settled_x, settled_y;

    debounce_chan #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_x (
        .clk      (clk),
        .reset_b  (reset_b),
        .raw_i    (raw_x),
        .level_o  (in_x),
        .settled_o(settled_x)
`ifdef COND_EDGE_EN
        ,
        .rise_o   (x_rise),
        .fall_o   (x_fall)
`endif
    );

    debounce_chan #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_y (
        .clk      (clk),
        .reset_b  (reset_b),
        .raw_i    (raw_y),
        .level_o  (in_y),
        .settled_o(settled_y)
`ifdef COND_EDGE_EN
        ,
        .rise_o   (y_rise),
        .fall_o   (y_fall)
`endif
    );

    // Channels are deliberately not aligned to each other.
    assign stable = settled_x & settled_y;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: run-length reference model plus directed and random scenarios.
module tb_input_conditioner;
    import input_conditioner_pkg::*;

    localparam int SYNC = DEF_SYNC_STAGES;
    localparam int STAB = DEF_STABLE_CYCLES;
    localparam int LAT  = SYNC + STAB - 1;

    logic clk = 1'b0, reset_b = 1'b0, raw_x = 1'b0, raw_y = 1'b0;
    logic in_x, in_y, stable;
`ifdef COND_EDGE_EN
    logic x_rise, x_fall, y_rise, y_fall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: raw levels reach the debouncer SYNC edges late; a level
    // is accepted once STAB consecutive samples differ from the current output.
    bit dq_x[$], dq_y[$];
    bit mx, my, mxr, mxf, myr, myf;
    int run_x, run_y;

    always #5 clk = ~clk;

    input_conditioner dut (
        .clk    (clk),
        .reset_b(reset_b),
        .raw_x  (raw_x),
        .raw_y  (raw_y),
        .in_x   (in_x),
        .in_y   (in_y),
        .stable (stable)
`ifdef COND_EDGE_EN
        ,
        .x_rise (x_rise),
        .x_fall (x_fall),
        .y_rise (y_rise),
        .y_fall (y_fall)
`endif
    );

    function automatic void chan(input bit s, inout bit lvl, inout int run,
                                 output bit rise, output bit fall);
        rise = 1'b0;
        fall = 1'b0;
        if (s == lvl) run = 0;
        else begin
            run++;
            if (run == STAB) begin
                lvl  = s;
                run  = 0;
                rise = s;
                fall = !s;
            end
        end
    endfunction

    task automatic mreset();
        dq_x.delete();
        dq_y.delete();
        repeat (SYNC) begin
            dq_x.push_back(1'b0);
            dq_y.push_back(1'b0);
        end
        mx = 0; my = 0; run_x = 0; run_y = 0;
        mxr = 0; mxf = 0; myr = 0; myf = 0;
    endtask

    // Drive raws at negedge, let one posedge happen, advance the model, settle #1.
    task automatic step(input bit rx, input bit ry);
        @(negedge clk);
        raw_x = rx;
        raw_y = ry;
        @(posedge clk);
        if (reset_b) begin
            dq_x.push_back(rx);
            dq_y.push_back(ry);
            chan(dq_x.pop_front(), mx, run_x, mxr, mxf);
            chan(dq_y.pop_front(), my, run_y, myr, myf);
        end
        #1;
    endtask

    function automatic logic [6:0] obs();
        obs = {in_x, in_y, stable, 4'b0000};
`ifdef COND_EDGE_EN
        obs[3:0] = {x_rise, x_fall, y_rise, y_fall};
`endif
    endfunction

    function automatic logic [6:0] expv();
        expv = {mx, my, (run_x == 0 && run_y == 0), 4'b0000};
`ifdef COND_EDGE_EN
        expv[3:0] = {mxr, mxf, myr, myf};
`endif
    endfunction

    task automatic settle();
        repeat (LAT + 3) step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        int lat;
        reset_b = 1'b0;
        mreset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1);
            n_tests++;
            if ({in_x, in_y, stable} !== 3'b001) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: got %b want 001", i, {in_x, in_y, stable});
            end
        end
        reset_b = 1'b1;
        lat = -1;
        for (int i = 0; i < LAT + 4; i++) begin
            step(1'b1, 1'b1);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL reset_release cyc %0d: got %b want %b", i, obs(), expv());
            end
            if (in_x && in_y && lat < 0) lat = i;
        end
        n_tests++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL reset_latency: got %0d want %0d", lat, LAT);
        end
    endtask

    task automatic test_bounce();
        int lat;
        settle();
        repeat (5) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        lat = -1;
        for (int i = 0; i < LAT + 5; i++) begin
            step(1'b1, 1'b0);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL bounce cyc %0d: got %b want %b", i, obs(), expv());
            end
            if (i == LAT - 1) begin
                n_tests++;
                if (stable !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bounce_wait_stable: got %b want 0", stable);
                end
            end
            if (in_x && lat < 0) lat = i;
        end
        n_tests++;
        if (lat !== LAT || in_y !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_latency: got lat %0d in_y %b want %0d 0", lat, in_y, LAT);
        end
    endtask

    task automatic test_glitch();
        bit seen;
        settle();
        seen = 0;
        repeat (3) begin
            step(1'b0, 1'b1);
            if (in_y) seen = 1;
        end
        for (int i = 0; i < LAT + 3; i++) begin
            step(1'b0, 1'b0);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL glitch cyc %0d: got %b want %b", i, obs(), expv());
            end
            if (in_y) seen = 1;
        end
        n_tests++;
        if (seen || stable !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_reject: got seen %0d stable %b want 0 1", seen, stable);
        end
    endtask

    task automatic test_simultaneous();
        int lx, ly;
        settle();
        lx = -1;
        ly = -1;
        for (int i = 0; i < LAT + 4; i++) begin
            step(1'b1, 1'b1);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL simul cyc %0d: got %b want %b", i, obs(), expv());
            end
            if (in_x && lx < 0) lx = i;
            if (in_y && ly < 0) ly = i;
        end
        n_tests++;
        if (lx !== LAT || ly !== LAT) begin
            n_fail++;
            $display("FAIL simul_latency: got x %0d y %0d want %0d", lx, ly, LAT);
        end
    endtask

    task automatic test_reset_midcount();
        int lat;
        settle();
        repeat (5) step(1'b1, 1'b0);
        #2 reset_b = 1'b0;
        #1;
        mreset();
        n_tests++;
        if ({in_x, stable} !== 2'b01) begin
            n_fail++;
            $display("FAIL midcount_async: got %b want 01", {in_x, stable});
        end
        repeat (3) step(1'b1, 1'b0);
        reset_b = 1'b1;
        lat = -1;
        for (int i = 0; i < LAT + 3; i++) begin
            step(1'b1, 1'b0);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL midcount cyc %0d: got %b want %b", i, obs(), expv());
            end
            if (in_x && lat < 0) lat = i;
        end
        n_tests++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL midcount_latency: got %0d want %0d", lat, LAT);
        end
        // Reset while the level is high must drop it without a clock edge.
        #2 reset_b = 1'b0;
        #1;
        mreset();
        n_tests++;
        if ({in_x, in_y, stable} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_from_hi: got %b want 001", {in_x, in_y, stable});
        end
        step(1'b0, 1'b0);
        reset_b = 1'b1;
    endtask

    task automatic test_random();
        bit lx, ly;
        int rem_x, rem_y;
        lx = 0; ly = 0; rem_x = 0; rem_y = 0;
        for (int i = 0; i < 600; i++) begin
            if (rem_x == 0) begin lx = ~lx; rem_x = $urandom_range(1, 14); end
            if (rem_y == 0) begin ly = ~ly; rem_y = $urandom_range(1, 14); end
            rem_x--;
            rem_y--;
            step(lx, ly);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b", i, obs(), expv());
            end
        end
    endtask

`ifdef COND_EDGE_EN
    task automatic test_edges();
        int nxr, nxf, nyp;
        settle();
        nxr = 0; nxf = 0; nyp = 0;
        for (int i = 0; i < 40; i++) begin
            step((i < 20) ? 1'b1 : 1'b0, 1'b0);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL edges cyc %0d: got %b want %b", i, obs(), expv());
            end
            nxr += int'(x_rise);
            nxf += int'(x_fall);
            nyp += int'(y_rise) + int'(y_fall);
        end
        n_tests++;
        if (nxr != 1 || nxf != 1 || nyp != 0) begin
            n_fail++;
            $display("FAIL edge_counts: got rise %0d fall %0d y %0d want 1 1 0", nxr, nxf, nyp);
        end
    endtask
`endif

    initial begin
        mreset();
        test_reset();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_midcount();
`ifdef COND_EDGE_EN
        test_edges();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
